regfile_sb: RTL

- Parametrised register file for the next-generation MIPS datapath.
- Generalised width and depth, with per-byte write enables, optional write-to-read bypass and optional hardwired-zero register 0.
- Asynchronous clear of all storage on reset.
- Per-register pending scoreboard: the issue stage marks a destination busy for a multi-cycle producer (load, multiply), and the writeback clears it. Hazard logic stalls on busy1/busy2.

---
 rtl/regfile_sb.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with per-byte write enables,
// optional write-to-read bypass, optional hardwired-zero register 0 and
// a per-register pending scoreboard for multi-cycle producers.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]      ra1,
    input  logic [AW-1:0]      ra2,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    input  logic               pend_set,
    input  logic [AW-1:0]      pend_wa,
    output logic               busy1,
    output logic               busy2,
    output logic               any_pending
);
    localparam int DEPTH = 2**AW;
    localparam int NB    = WIDTH/8;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0]            pend_q, pend_d;
    logic [WIDTH-1:0]            wr_merge;
    logic                        wa_live;
    logic [1:0][AW-1:0]          ra_v;
    logic [1:0][WIDTH-1:0]       rd_v;
    logic [1:0]                  busy_v;

    // A write to a hardwired-zero register 0 never reaches storage.
    assign wa_live = !(ZR && (wa == '0));

    // Storage: byte-masked write, whole array cleared by async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else if (we && wa_live) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) mem_q[wa][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    // Value the target register will hold after this edge (forwarding source).
    always_comb begin
        wr_merge = mem_q[wa];
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) wr_merge[8*b +: 8] = wd[8*b +: 8];
        end
    end

    // Read ports: stored data, overridden by bypass, overridden by zero reg.
    // Bypass is gated by reset so outputs read zero while reset is held.
    assign ra_v = {ra2, ra1};
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_v[p]   = mem_q[ra_v[p]];
            busy_v[p] = pend_q[ra_v[p]];
            if (BP && we && !reset && (ra_v[p] == wa)) begin
                rd_v[p]   = wr_merge;
                busy_v[p] = 1'b0;
            end
            if (ZR && (ra_v[p] == '0)) begin
                rd_v[p]   = '0;
                busy_v[p] = 1'b0;
            end
        end
    end

    assign rd1   = rd_v[0];
    assign rd2   = rd_v[1];
    assign busy1 = busy_v[0];
    assign busy2 = busy_v[1];

    // Scoreboard next state: writeback clears, issue sets; set applied last
    // so a newer producer issuing onto a retiring one keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (we)       pend_d[wa]      = 1'b0;
        if (pend_set) pend_d[pend_wa] = 1'b1;
        if (ZR)       pend_d[0]       = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign any_pending = |pend_q;
endmodule
